// File: rtl/fsm_control.sv
// Main control FSM for the FIFO datapath: sequences RESET/INIT/IDLE/ACTIVE/ERROR,
// holds the almost-empty/almost-full thresholds and a sticky per-FIFO error record.
module fsm_control #(
  parameter int N            = 5,
  parameter int UMB_W        = 3,
  parameter int UMB_BAJO_RST = 1,
  parameter int UMB_ALTO_RST = 6
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [UMB_W-1:0] umbral_bajo_in,
  input  logic [UMB_W-1:0] umbral_alto_in,
  input  logic [N-1:0]     fifo_empty,
  input  logic [N-1:0]     fifo_error,
  output logic [4:0]       state,
  output logic             idle,
  output logic [UMB_W-1:0] umbral_bajo_out,
  output logic [UMB_W-1:0] umbral_alto_out,
  output logic             cfg_invalid,
  output logic [N-1:0]     error_out
);

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  state_t           state_q, state_d;
  logic [UMB_W-1:0] umb_bajo_q, umb_bajo_d;
  logic [UMB_W-1:0] umb_alto_q, umb_alto_d;
  logic             cfg_invalid_q, cfg_invalid_d;
  logic [N-1:0]     error_q, error_d;

  logic cfg_valid;
  logic any_error;
  logic all_empty;

  assign cfg_valid = (umbral_bajo_in < umbral_alto_in);
  assign any_error = |fifo_error;
  assign all_empty = (fifo_empty == {N{1'b1}});

  always_comb begin
    state_d       = state_q;
    umb_bajo_d    = umb_bajo_q;
    umb_alto_d    = umb_alto_q;
    cfg_invalid_d = 1'b0;
    error_d       = error_q;

    // Threshold load is independent of the transition taken, so an INIT->ERROR
    // edge still captures a valid pair.
    if (state_q == ST_INIT) begin
      if (cfg_valid) begin
        umb_bajo_d = umbral_bajo_in;
        umb_alto_d = umbral_alto_in;
      end else begin
        cfg_invalid_d = 1'b1;
      end
    end

    if (state_q == ST_RESET) begin
      state_d = ST_INIT;
    end else begin
      error_d = error_q | fifo_error;
      if (any_error) begin
        state_d = ST_ERROR;
      end else begin
        case (state_q)
          ST_INIT: begin
            if (!init && cfg_valid) state_d = ST_IDLE;
            else                    state_d = ST_INIT;
          end
          ST_IDLE: begin
            if (init)            state_d = ST_INIT;
            else if (!all_empty) state_d = ST_ACTIVE;
            else                 state_d = ST_IDLE;
          end
          ST_ACTIVE: begin
            if (init)           state_d = ST_INIT;
            else if (all_empty) state_d = ST_IDLE;
            else                state_d = ST_ACTIVE;
          end
          ST_ERROR: state_d = ST_ERROR;
          default:  state_d = ST_RESET;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q       <= ST_RESET;
      umb_bajo_q    <= UMB_W'(UMB_BAJO_RST);
      umb_alto_q    <= UMB_W'(UMB_ALTO_RST);
      cfg_invalid_q <= 1'b0;
      error_q       <= '0;
    end else begin
      state_q       <= state_d;
      umb_bajo_q    <= umb_bajo_d;
      umb_alto_q    <= umb_alto_d;
      cfg_invalid_q <= cfg_invalid_d;
      error_q       <= error_d;
    end
  end

  assign state           = state_q;
  assign idle            = state_q[2];
  assign umbral_bajo_out = umb_bajo_q;
  assign umbral_alto_out = umb_alto_q;
  assign cfg_invalid     = cfg_invalid_q;
  assign error_out       = error_q;

endmodule

// File: tb/tb_fsm_control.sv
// Directed bench for fsm_control: linear stimulus with hand-computed expectations.
module tb_fsm_control;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic [2:0] umbral_bajo_in;
  logic [2:0] umbral_alto_in;
  logic [4:0] fifo_empty;
  logic [4:0] fifo_error;
  logic [4:0] state;
  logic       idle;
  logic [2:0] umbral_bajo_out;
  logic [2:0] umbral_alto_out;
  logic       cfg_invalid;
  logic [4:0] error_out;

  int n_checks = 0;
  int n_fail   = 0;

  fsm_control #(.N(5), .UMB_W(3), .UMB_BAJO_RST(1), .UMB_ALTO_RST(6)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .init            (init),
    .umbral_bajo_in  (umbral_bajo_in),
    .umbral_alto_in  (umbral_alto_in),
    .fifo_empty      (fifo_empty),
    .fifo_error      (fifo_error),
    .state           (state),
    .idle            (idle),
    .umbral_bajo_out (umbral_bajo_out),
    .umbral_alto_out (umbral_alto_out),
    .cfg_invalid     (cfg_invalid),
    .error_out       (error_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] st, input logic [2:0] lo,
                         input logic [2:0] hi, input logic inv, input logic [4:0] err);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".idle"}, 32'(idle), 32'(st == 5'b00100));
    chk({tag, ".bajo"}, 32'(umbral_bajo_out), 32'(lo));
    chk({tag, ".alto"}, 32'(umbral_alto_out), 32'(hi));
    chk({tag, ".cfg_invalid"}, 32'(cfg_invalid), 32'(inv));
    chk({tag, ".error_out"}, 32'(error_out), 32'(err));
  endtask

  initial begin
    reset_L = 1'b0; init = 1'b0;
    umbral_bajo_in = 3'd1; umbral_alto_in = 3'd6;
    fifo_empty = 5'b11111; fifo_error = 5'b00000;

    // Reset held two cycles
    tick(); tick();
    chk_all("reset", 5'b00001, 3'd1, 3'd6, 1'b0, 5'b00000);

    reset_L = 1'b1;
    tick();
    chk_all("rst_to_init", 5'b00010, 3'd1, 3'd6, 1'b0, 5'b00000);
    tick();
    chk_all("init_to_idle", 5'b00100, 3'd1, 3'd6, 1'b0, 5'b00000);

    // IDLE -> INIT, program 2/5
    init = 1'b1; umbral_bajo_in = 3'd2; umbral_alto_in = 3'd5;
    tick();
    chk_all("idle_to_init", 5'b00010, 3'd1, 3'd6, 1'b0, 5'b00000);
    tick();
    chk_all("init_hold_load", 5'b00010, 3'd2, 3'd5, 1'b0, 5'b00000);
    init = 1'b0;
    tick();
    chk_all("init_exit", 5'b00100, 3'd2, 3'd5, 1'b0, 5'b00000);

    // Equal thresholds rejected, then 4/7 accepted on the exit edge
    init = 1'b1;
    tick();
    chk_all("reenter_init", 5'b00010, 3'd2, 3'd5, 1'b0, 5'b00000);
    init = 1'b0; umbral_bajo_in = 3'd4; umbral_alto_in = 3'd4;
    tick();
    chk_all("equal_invalid", 5'b00010, 3'd2, 3'd5, 1'b1, 5'b00000);
    umbral_bajo_in = 3'd5; umbral_alto_in = 3'd3;
    tick();
    chk_all("inverted_invalid", 5'b00010, 3'd2, 3'd5, 1'b1, 5'b00000);
    umbral_bajo_in = 3'd4; umbral_alto_in = 3'd7;
    tick();
    chk_all("valid_exit_load", 5'b00100, 3'd4, 3'd7, 1'b0, 5'b00000);

    // IDLE <-> ACTIVE on fifo_empty
    fifo_empty = 5'b10111;
    tick();
    chk_all("idle_to_active", 5'b01000, 3'd4, 3'd7, 1'b0, 5'b00000);
    tick();
    chk_all("active_stay", 5'b01000, 3'd4, 3'd7, 1'b0, 5'b00000);
    fifo_empty = 5'b11111;
    tick();
    chk_all("active_to_idle", 5'b00100, 3'd4, 3'd7, 1'b0, 5'b00000);
    fifo_empty = 5'b11110;
    tick();
    chk_all("idle_to_active2", 5'b01000, 3'd4, 3'd7, 1'b0, 5'b00000);

    // Error with simultaneous init: ERROR wins
    fifo_error = 5'b00100; init = 1'b1;
    tick();
    chk_all("active_to_error", 5'b10000, 3'd4, 3'd7, 1'b0, 5'b00100);
    fifo_error = 5'b00000; init = 1'b0;
    tick();
    chk_all("error_sticky", 5'b10000, 3'd4, 3'd7, 1'b0, 5'b00100);
    fifo_error = 5'b00001;
    tick();
    chk_all("error_accum", 5'b10000, 3'd4, 3'd7, 1'b0, 5'b00101);
    fifo_error = 5'b00000; init = 1'b1; fifo_empty = 5'b11111;
    tick();
    chk_all("error_terminal", 5'b10000, 3'd4, 3'd7, 1'b0, 5'b00101);
    reset_L = 1'b0;
    tick();
    chk_all("error_reset", 5'b00001, 3'd1, 3'd6, 1'b0, 5'b00000);

    // Reset in INIT while an invalid flag is set and 3/6 is presented
    reset_L = 1'b1; init = 1'b1; umbral_bajo_in = 3'd6; umbral_alto_in = 3'd3;
    fifo_error = 5'b11111;
    tick();
    chk_all("reset_ignores_err", 5'b00010, 3'd1, 3'd6, 1'b0, 5'b00000);
    fifo_error = 5'b00000;
    tick();
    chk_all("init_invalid_flag", 5'b00010, 3'd1, 3'd6, 1'b1, 5'b00000);
    umbral_bajo_in = 3'd3; umbral_alto_in = 3'd6; reset_L = 1'b0;
    tick();
    chk_all("mid_init_reset", 5'b00001, 3'd1, 3'd6, 1'b0, 5'b00000);

    // Error in INIT with a valid pair: ERROR wins, pair still loaded
    reset_L = 1'b1; init = 1'b0; umbral_bajo_in = 3'd2; umbral_alto_in = 3'd6;
    tick();
    chk_all("rst_to_init2", 5'b00010, 3'd1, 3'd6, 1'b0, 5'b00000);
    umbral_bajo_in = 3'd3; umbral_alto_in = 3'd5; fifo_error = 5'b00010;
    tick();
    chk_all("init_err_load", 5'b10000, 3'd3, 3'd5, 1'b0, 5'b00010);
    fifo_error = 5'b00000; reset_L = 1'b0;
    tick();
    chk_all("final_reset", 5'b00001, 3'd1, 3'd6, 1'b0, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
